// File: rtl/theia_mem_pkg.sv
// -----------------------------------------------------------------------------
// theia_mem_pkg
// Shared definitions for the THEIA main-memory side blocks:
//   - memRdState_t        : read responder state encoding (3 bits)
//   - MEM_ERROR_PATTERN   : word returned for a rejected (out-of-range) read
//   - MEM_DEFAULT_*       : default data / RAM address widths
//   - MEM_WAIT_COUNT_WIDTH: width of the wait-state down-counter (0..15)
// -----------------------------------------------------------------------------
package theia_mem_pkg;

    localparam int MEM_DEFAULT_DATA_WIDTH     = 32;
    localparam int MEM_DEFAULT_RAM_ADDR_WIDTH = 9;
    localparam int MEM_WAIT_COUNT_WIDTH       = 4;

    localparam logic [31:0] MEM_ERROR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4,
        ST_RELEASE = 3'd5
    } memRdState_t;

endpackage

// File: rtl/theia_mem_wait_counter.sv
// -----------------------------------------------------------------------------
// theia_mem_wait_counter
// Loadable down-counter with a terminal flag, shared by memory-side blocks.
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   synchronous active-low reset (count and flag to 0)
//   iLoad      in   load iLoadValue (has priority over iDecrement)
//   iLoadValue in   value to load
//   iDecrement in   decrement by one, saturating at zero
//   oCount     out  current count (registered)
//   oTerminal  out  registered flag, high while the count equals 1, i.e. during
//                   the final cycle of a wait sequence
// -----------------------------------------------------------------------------
module theia_mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadValue,
    input  logic             iDecrement,
    output logic [WIDTH-1:0] oCount,
    output logic             oTerminal
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] nextCount_s;
    logic             terminal_r;

    // Next count: load wins, decrement never wraps below zero.
    always_comb begin
        nextCount_s = count_r;
        if (iLoad) begin
            nextCount_s = iLoadValue;
        end else if (iDecrement && (count_r != {WIDTH{1'b0}})) begin
            nextCount_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            nextCount_s = count_r;
        end
    end

    // Count register; the terminal flag is precomputed from the next count so
    // it is a plain register aligned with oCount.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_r    <= {WIDTH{1'b0}};
            terminal_r <= 1'b0;
        end else begin
            count_r    <= nextCount_s;
            terminal_r <= (nextCount_s == {{(WIDTH-1){1'b0}}, 1'b1});
        end
    end

    assign oCount    = count_r;
    assign oTerminal = terminal_r;

endmodule

// File: rtl/theia_mem_read_responder.sv
// -----------------------------------------------------------------------------
// theia_mem_read_responder
// Far end of the THEIA GPU memory read port. Each accepted read request becomes
// one access on a synchronous single-port RAM (data valid the cycle after the
// read strobe); the word is returned with a one-cycle data-available pulse.
// A 4-phase handshake (RELEASE waits for the request to drop) guarantees a held
// request is serviced exactly once.
//
// Timing relative to the edge that accepts the request in IDLE:
//   +1 ISSUE (RAM strobe), +2 CAPTURE, +3..+2+WAIT_STATES WAIT,
//   +3+WAIT_STATES RESP (pulse), then RELEASE until the request is low.
//
// Ports:
//   Clock              in   system clock
//   Reset              in   synchronous active-low reset
//   iMEM_ReadRequest   in   level request, held until data available
//   iMemReadAddress    in   word address, sampled on acceptance only
//   oMemReadData       out  returned word, held until the next response
//   oMemDataAvailable  out  one-cycle pulse, oMemReadData valid in that cycle
//   oRamAddress        out  RAM address (accepted address, low bits)
//   oRamReadEnable     out  RAM read strobe, one cycle per access
//   iRamReadData       in   RAM read data
//   oBusy              out  high in every state except IDLE
//   oAddrError         out  sticky out-of-range flag (THEIA_MEM_RANGE_CHECK_EN)
//
// Optional feature macro: THEIA_MEM_RANGE_CHECK_EN
//   defined   : addresses >= RAM_DEPTH are rejected (no RAM strobe, response
//               is 32'hDEAD_BEEF, oAddrError set until reset)
//   undefined : no check, address wraps by truncation to RAM_ADDR_WIDTH bits
// -----------------------------------------------------------------------------
module theia_mem_read_responder
    import theia_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = MEM_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = MEM_DEFAULT_RAM_ADDR_WIDTH,
    parameter int RAM_DEPTH      = 510,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iMEM_ReadRequest,
    input  logic [ADDR_WIDTH-1:0]     iMemReadAddress,
    output logic [DATA_WIDTH-1:0]     oMemReadData,
    output logic                      oMemDataAvailable,
    output logic [RAM_ADDR_WIDTH-1:0] oRamAddress,
    output logic                      oRamReadEnable,
    input  logic [DATA_WIDTH-1:0]     iRamReadData,
    output logic                      oBusy
`ifdef THEIA_MEM_RANGE_CHECK_EN
    ,
    output logic                      oAddrError
`endif
);

    memRdState_t state_r;
    memRdState_t nextState_s;

    logic                      acceptReq_s;
    logic                      rangeErr_s;
    logic                      loadCounter_s;
    logic                      decCounter_s;
    logic                      counterTerminal_s;
    logic [MEM_WAIT_COUNT_WIDTH-1:0] unusedWaitCount_s;
    logic                      unusedAddrBits_s;
    logic [DATA_WIDTH-1:0]     respData_s;

    logic [RAM_ADDR_WIDTH-1:0] latchedAddr_r;
    logic                      accessErr_r;
    logic                      ramReadEnable_r;
    logic [DATA_WIDTH-1:0]     captureData_r;
    logic [DATA_WIDTH-1:0]     memReadData_r;
    logic                      dataAvailable_r;
    logic                      busy_r;

    assign acceptReq_s = (state_r == ST_IDLE) && iMEM_ReadRequest;

    // Upper address bits only matter to the range check; without it they are
    // deliberately dropped (address wraps).
    assign unusedAddrBits_s = ^iMemReadAddress[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

`ifdef THEIA_MEM_RANGE_CHECK_EN
    logic addrError_r;

    assign rangeErr_s = acceptReq_s && (iMemReadAddress >= ADDR_WIDTH'(RAM_DEPTH));

    // Sticky range-error flag; only reset clears it.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addrError_r <= 1'b0;
        end else begin
            addrError_r <= addrError_r | rangeErr_s;
        end
    end

    assign oAddrError = addrError_r;
`else
    logic [31:0] unusedDepth_s;

    assign unusedDepth_s = 32'(RAM_DEPTH);
    assign rangeErr_s    = 1'b0;
`endif

    theia_mem_wait_counter #(
        .WIDTH(MEM_WAIT_COUNT_WIDTH)
    ) uWaitCounter (
        .Clock      (Clock),
        .Reset      (Reset),
        .iLoad      (loadCounter_s),
        .iLoadValue (MEM_WAIT_COUNT_WIDTH'(WAIT_STATES)),
        .iDecrement (decCounter_s),
        .oCount     (unusedWaitCount_s),
        .oTerminal  (counterTerminal_s)
    );

    // Next-state logic and wait-counter control.
    always_comb begin
        nextState_s   = state_r;
        loadCounter_s = 1'b0;
        decCounter_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iMEM_ReadRequest) begin
                    nextState_s = ST_ISSUE;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                nextState_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (WAIT_STATES == 0) begin
                    nextState_s = ST_RESP;
                end else begin
                    loadCounter_s = 1'b1;
                    nextState_s   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Terminal flag marks the cycle the count is 1: leave now so
                // RESP follows exactly WAIT_STATES wait cycles.
                decCounter_s = 1'b1;
                if (counterTerminal_s) begin
                    nextState_s = ST_RESP;
                end else begin
                    nextState_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                nextState_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!iMEM_ReadRequest) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_RELEASE;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // Response word: error pattern for rejected reads; with no wait states the
    // RAM word is forwarded straight from the capture cycle.
    always_comb begin
        respData_s = captureData_r;
        if (accessErr_r) begin
            respData_s = DATA_WIDTH'(MEM_ERROR_PATTERN);
        end else if (state_r == ST_CAPTURE) begin
            respData_s = iRamReadData;
        end else begin
            respData_s = captureData_r;
        end
    end

    // State register and registered outputs (outputs follow the next state so
    // they line up with the state they belong to).
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r         <= ST_IDLE;
            latchedAddr_r   <= {RAM_ADDR_WIDTH{1'b0}};
            accessErr_r     <= 1'b0;
            ramReadEnable_r <= 1'b0;
            captureData_r   <= {DATA_WIDTH{1'b0}};
            memReadData_r   <= {DATA_WIDTH{1'b0}};
            dataAvailable_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (acceptReq_s) begin
                latchedAddr_r <= iMemReadAddress[RAM_ADDR_WIDTH-1:0];
                accessErr_r   <= rangeErr_s;
            end
            ramReadEnable_r <= acceptReq_s && !rangeErr_s;
            if (state_r == ST_CAPTURE) begin
                captureData_r <= iRamReadData;
            end
            dataAvailable_r <= (nextState_s == ST_RESP);
            if (nextState_s == ST_RESP) begin
                memReadData_r <= respData_s;
            end
            busy_r <= (nextState_s != ST_IDLE);
        end
    end

    assign oRamAddress       = latchedAddr_r;
    assign oRamReadEnable    = ramReadEnable_r;
    assign oMemReadData      = memReadData_r;
    assign oMemDataAvailable = dataAvailable_r;
    assign oBusy             = busy_r;

endmodule

// File: tb/tb_theia_mem_read_responder.sv
// -----------------------------------------------------------------------------
// tb_theia_mem_read_responder
// Two responders share one clock and one backing memory image: index 0 has no
// wait states, index 1 has three. A transaction-level model predicts, per
// cycle after acceptance, the strobe, pulse, data, busy and error flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_theia_mem_read_responder;

    localparam int DEPTH = 510;
`ifdef THEIA_MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        rst      [2];
    logic        req      [2];
    logic [31:0] addr     [2];
    logic [31:0] rdata    [2];
    logic        avail    [2];
    logic [8:0]  ramAddr  [2];
    logic        ren      [2];
    logic [31:0] ramData  [2];
    logic        busy     [2];
`ifdef THEIA_MEM_RANGE_CHECK_EN
    logic        addrErr  [2];
`endif

    logic [31:0] mem [512];
    logic [31:0] lastData     [2];
    int          lastPulseCyc [2];
    bit          stickyErr    [2];
    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Synchronous RAM: word valid the cycle after the strobe, noise otherwise.
    always @(posedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (ren[k]) ramData[k] <= mem[ramAddr[k]];
            else        ramData[k] <= $urandom();
        end
    end

    theia_mem_read_responder #(.WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Reset(rst[0]), .iMEM_ReadRequest(req[0]),
        .iMemReadAddress(addr[0]), .oMemReadData(rdata[0]),
        .oMemDataAvailable(avail[0]), .oRamAddress(ramAddr[0]),
        .oRamReadEnable(ren[0]), .iRamReadData(ramData[0]), .oBusy(busy[0])
`ifdef THEIA_MEM_RANGE_CHECK_EN
        , .oAddrError(addrErr[0])
`endif
    );

    theia_mem_read_responder #(.WAIT_STATES(3)) dut1 (
        .Clock(Clock), .Reset(rst[1]), .iMEM_ReadRequest(req[1]),
        .iMemReadAddress(addr[1]), .oMemReadData(rdata[1]),
        .oMemDataAvailable(avail[1]), .oRamAddress(ramAddr[1]),
        .oRamReadEnable(ren[1]), .iRamReadData(ramData[1]), .oBusy(busy[1])
`ifdef THEIA_MEM_RANGE_CHECK_EN
        , .oAddrError(addrErr[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic check_all_zero(input int i);
        check_eq("rstRamEnable", {31'd0, ren[i]}, 32'd0);
        check_eq("rstRamAddress", {23'd0, ramAddr[i]}, 32'd0);
        check_eq("rstAvail", {31'd0, avail[i]}, 32'd0);
        check_eq("rstData", rdata[i], 32'd0);
        check_eq("rstBusy", {31'd0, busy[i]}, 32'd0);
`ifdef THEIA_MEM_RANGE_CHECK_EN
        check_eq("rstAddrError", {31'd0, addrErr[i]}, 32'd0);
`endif
    endtask

    // One read on responder i, called at a negedge with the DUT in IDLE (or
    // in reset when releaseReset is set). The request drops after cycle dropAt.
    task automatic do_read(input int i, input logic [31:0] a, input int dropAt, input bit releaseReset);
        int          lat;
        int          n;
        bit          err;
        bit          relActive;
        bit          done;
        logic [31:0] expData;
        lat     = (i == 0) ? 3 : 6;
        err     = RANGE_CHECK && (a >= 32'(DEPTH));
        expData = err ? 32'hDEAD_BEEF : mem[a % 32'd512];
        req[i]  = 1'b1;
        addr[i] = a;
        if (releaseReset) rst[i] = 1'b1;
        relActive = 1'b0;
        done      = 1'b0;
        n         = 0;
        while (!done && n < 40) begin
            @(negedge Clock);
            n++;
            if (err) stickyErr[i] = 1'b1;
            check_eq("ramEnable", {31'd0, ren[i]}, {31'd0, (n == 1) && !err});
            if (n == 1 && !err) begin
                check_eq("ramAddress", {23'd0, ramAddr[i]}, a % 32'd512);
                check_eq("strobeGap", {31'd0, (cyc - lastPulseCyc[i]) >= 2}, 32'd1);
            end
            check_eq("dataAvailable", {31'd0, avail[i]}, {31'd0, n == lat});
            if (n == lat) begin
                lastData[i]     = expData;
                lastPulseCyc[i] = cyc;
            end
            check_eq("readData", rdata[i], lastData[i]);
            if (n == lat + 1) relActive = 1'b1;
            check_eq("busy", {31'd0, busy[i]}, {31'd0, (n <= lat) || relActive});
`ifdef THEIA_MEM_RANGE_CHECK_EN
            check_eq("addrError", {31'd0, addrErr[i]}, {31'd0, stickyErr[i]});
`endif
            if (n > lat && !relActive) begin
                done = 1'b1;
            end else begin
                if (n >= dropAt) req[i] = 1'b0;
                addr[i] = $urandom();
                if (relActive && !req[i]) relActive = 1'b0;
            end
        end
        check_eq("completed", {31'd0, done}, 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 512; k++) mem[k] = $urandom();
        mem[5] = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            rst[i]          = 1'b0;
            req[i]          = 1'b1;
            addr[i]         = 32'd5;
            lastData[i]     = 32'd0;
            lastPulseCyc[i] = -1000;
            stickyErr[i]    = 1'b0;
        end

        // Reset held with the request high: everything stays at zero.
        repeat (3) begin
            @(negedge Clock);
            check_all_zero(0);
            check_all_zero(1);
        end

        // Held request accepted right after reset releases; one pulse only.
        do_read(0, 32'd5, 6, 1'b1);
        // Three wait states, last RAM word; released from reset with request held.
        do_read(1, 32'd509, 9, 1'b1);

        // Back-to-back with one low request cycle in between.
        do_read(0, 32'd0, 3, 1'b0);
        do_read(0, 32'd1, 3, 1'b0);
        do_read(1, 32'd0, 6, 1'b0);
        do_read(1, 32'd1, 6, 1'b0);

        // Reset while in WAIT: access dropped, no pulse, data and counter cleared.
        req[1]  = 1'b1;
        addr[1] = 32'd77;
        repeat (4) @(negedge Clock);
        check_eq("inWaitBusy", {31'd0, busy[1]}, 32'd1);
        rst[1] = 1'b0;
        req[1] = 1'b0;
        @(negedge Clock);
        rst[1]          = 1'b1;
        lastData[1]     = 32'd0;
        stickyErr[1]    = 1'b0;
        check_all_zero(1);
        repeat (8) begin
            @(negedge Clock);
            check_eq("postRstAvail", {31'd0, avail[1]}, 32'd0);
            check_eq("postRstBusy", {31'd0, busy[1]}, 32'd0);
            check_eq("postRstData", rdata[1], 32'd0);
            check_eq("postRstCount", {28'd0, dut1.uWaitCounter.oCount}, 32'd0);
        end

        // Address 510: rejected with range check, wraps unchecked without.
        do_read(0, 32'd510, 4, 1'b0);
        do_read(1, 32'd510, 7, 1'b0);
        do_read(0, 32'd7, 4, 1'b0);
        do_read(1, 32'd8, 7, 1'b0);

        // Randomized reads: random responder, address, drop point and gaps.
        for (int t = 0; t < 40; t++) begin
            int          i;
            int          gap;
            logic [31:0] a;
            i   = int'($urandom_range(0, 1));
            a   = RANGE_CHECK ? 32'($urandom_range(0, 600)) : $urandom();
            do_read(i, a, int'($urandom_range(1, (i == 0) ? 6 : 9)), 1'b0);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge Clock);
                check_eq("idleAvail", {31'd0, avail[i]}, 32'd0);
                check_eq("idleBusy", {31'd0, busy[i]}, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
